// File: rtl/rf_dump.sv
// Register file read-out engine on RF read port 1.
// Walks first..last (mod 2^ADDR_W) and streams {addr, data} pairs.
module rf_dump #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] RA,
  input  logic [DATA_W-1:0] RD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    FIN
  } state_e;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] nxt;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    nxt         = cur_q + ONE;
    RA          = '0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_addr;
          end_d   = last_addr;
          busy_d  = 1'b1;
          state_d = READ;
          // $zero alone in range: nothing to emit
          if (SKIP_ZERO && first_addr == '0) begin
            if (last_addr == '0) state_d = FIN;
            else cur_d = ONE;
          end
        end
      end
      READ: begin
        RA          = cur_q;
        out_data_d  = RD;
        out_addr_d  = cur_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        RA = cur_q;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (cur_q == end_q) begin
            state_d = FIN;
          end else if (SKIP_ZERO && nxt == '0) begin
            // skipping $zero steps past an end of 0
            if (end_q == '0) begin
              state_d = FIN;
            end else begin
              cur_d   = ONE;
              state_d = READ;
            end
          end else begin
            cur_d   = nxt;
            state_d = READ;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: one instance per SKIP_ZERO setting,
// sharing a behavioural register file.
module tb_rf_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [4:0]  first_a, last_a;
  logic        ready;
  logic [4:0]  ra0, ra1, oa0, oa1;
  logic [31:0] rd0, rd1, od0, od1;
  logic        v0, v1, busy0, busy1, done0, done1;

  logic [31:0] rf [32];
  logic [4:0]  exp_a [$];
  logic [31:0] exp_d [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rd0 = rf[ra0];
  assign rd1 = rf[ra1];

  rf_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .first_addr(first_a), .last_addr(last_a),
    .RA(ra0), .RD(rd0),
    .out_valid(v0), .out_ready(ready),
    .out_addr(oa0), .out_data(od0),
    .busy(busy0), .done(done0)
  );

  rf_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .first_addr(first_a), .last_addr(last_a),
    .RA(ra1), .RD(rd1),
    .out_valid(v1), .out_ready(ready),
    .out_addr(oa1), .out_data(od1),
    .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a);
    exp_a.push_back(a);
    exp_d.push_back(rf[a]);
  endtask

  // Runs one dump against the queued expectations. ready is held low
  // for `hold` cycles after the first pair appears. A stray start is
  // pulsed at cycle 1 (READ or FIN) and must be ignored.
  task automatic do_dump(input bit sz, input logic [4:0] f,
                         input logic [4:0] l, input int hold);
    int idx, ndone, done_cyc, acc_last, n;
    logic v, d, b;
    logic [4:0] oa, ra;
    logic [31:0] od;
    n = exp_a.size();
    idx = 0; ndone = 0; done_cyc = -1; acc_last = 0;
    first_a = f; last_a = l; ready = 1'b0;
    if (sz) start1 = 1'b1; else start0 = 1'b1;
    for (int cyc = 1; cyc < 80; cyc++) begin
      tick();
      if (cyc == 1) begin
        first_a = 5'd20; last_a = 5'd20;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      ready = (cyc >= 2 + hold);
      v  = sz ? v1 : v0;
      d  = sz ? done1 : done0;
      b  = sz ? busy1 : busy0;
      oa = sz ? oa1 : oa0;
      od = sz ? od1 : od0;
      ra = sz ? ra1 : ra0;
      if (v) begin
        if (idx < n) begin
          check("pair_addr", 64'(oa), 64'(exp_a[idx]));
          check("pair_data", 64'(od), 64'(exp_d[idx]));
          check("pair_ra", 64'(ra), 64'(exp_a[idx]));
          if (ready) begin
            check("pair_cycle", 64'(cyc), 64'(2 + hold + 2 * idx));
            acc_last = cyc;
            idx++;
          end
        end else begin
          check("extra_pair", 64'(oa), 64'hFFFF);
        end
      end
      if (d) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = cyc;
          check("busy_at_done", 64'(b), 64'd1);
        end
      end
      if (ndone > 0 && cyc == done_cyc + 1) begin
        check("busy_after", 64'(b), 64'd0);
        check("done_width", 64'(d), 64'd0);
        break;
      end
    end
    ready = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    check("pair_count", 64'(idx), 64'(n));
    check("done_count", 64'(ndone), 64'd1);
    check("done_cycle", 64'(done_cyc),
          (n == 0) ? 64'd1 : 64'(acc_last + 1));
    exp_a.delete();
    exp_d.delete();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1]  = 32'h11111111; rf[2]  = 32'h22222222;
    rf[3]  = 32'h33333333; rf[4]  = 32'h44444444;
    rf[5]  = 32'h55555555; rf[7]  = 32'h77777777;
    rf[20] = 32'h20202020;
    rf[30] = 32'hAAAA0030; rf[31] = 32'hAAAA0031;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    first_a = '0; last_a = '0; ready = 1'b0;
    tick(); tick();
    check("rst_ra", 64'(ra0), 64'd0);
    check("rst_valid", 64'(v0), 64'd0);
    check("rst_addr", 64'(oa0), 64'd0);
    check("rst_data", 64'(od0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0 | done1 | v1 | busy1), 64'd0);
    rst_n = 1'b1;
    tick();

    push(1); push(2); push(3); push(4);
    do_dump(1'b0, 5'd1, 5'd4, 0);

    push(2); push(3);
    do_dump(1'b0, 5'd2, 5'd3, 5);

    push(30); push(31); push(0); push(1);
    do_dump(1'b0, 5'd30, 5'd1, 0);

    push(30); push(31); push(1);
    do_dump(1'b1, 5'd30, 5'd1, 0);

    push(7);
    do_dump(1'b0, 5'd7, 5'd7, 0);

    do_dump(1'b1, 5'd0, 5'd0, 0);

    // RF write while a pair is held must not disturb out_data
    first_a = 5'd5; last_a = 5'd5; ready = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("stale_pre", 64'(od0), 64'h55555555);
    rf[5] = 32'hDEADBEEF;
    tick();
    check("stale_hold", 64'(od0), 64'h55555555);
    check("stale_valid", 64'(v0), 64'd1);
    check("stale_ra", 64'(ra0), 64'd5);
    ready = 1'b1;
    tick();
    check("stale_done", 64'(done0), 64'd1);
    ready = 1'b0;
    tick();
    check("stale_idle", 64'(busy0), 64'd0);
    push(5);
    do_dump(1'b0, 5'd5, 5'd5, 0);

    // reset during HOLD drops the pair with no done
    first_a = 5'd1; last_a = 5'd4; ready = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("mid_hold_valid", 64'(v0), 64'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(v0), 64'd0);
    check("mid_rst_busy", 64'(busy0), 64'd0);
    check("mid_rst_ra", 64'(ra0), 64'd0);
    check("mid_rst_done", 64'(done0), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", 64'(done0 | v0), 64'd0);
    end
    push(1); push(2); push(3); push(4);
    do_dump(1'b0, 5'd1, 5'd4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
